frame_arbiter: RTL and testbench

//  Shares one framed output stream between N_REQ framed requesters.
//  - Arbitration is round-robin and happens only at frame boundaries.
//  - The grant is held from the SOP beat to the EOP beat, so frames never interleave.
//  - Stray beats that arrive outside a frame are discarded and counted.
//  - An SOP seen inside a granted frame is masked and flagged.
//  - Sits upstream of the framing checker and feeds it well-formed frames.

---
 rtl/frame_arbiter_if.sv | 30 +++
 rtl/frame_arbiter.sv | 145 ++++++++++++++
 tb/tb_frame_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_arbiter_if.sv
// Framed stream bundle between N_REQ requesters and the shared output.
// Handshake: a requester beat moves on a rising i_clk edge when i_valid[k] && o_ready[k].
// A requester keeps i_valid/i_sop/i_eop/i_data stable until that edge. The output side
// has no back-pressure, so an o_valid beat is consumed in the cycle it is shown.
interface frame_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        i_valid;
    logic [N_REQ-1:0]        i_sop;
    logic [N_REQ-1:0]        i_eop;
    logic [N_REQ*DATA_W-1:0] i_data;
    logic [N_REQ-1:0]        o_ready;
    logic                    o_valid;
    logic                    o_sop;
    logic                    o_eop;
    logic [DATA_W-1:0]       o_data;

    // Requester side: drives the beats and sees the accepts and the merged stream.
    modport master (
        output i_valid, i_sop, i_eop, i_data,
        input  o_ready, o_valid, o_sop, o_eop, o_data
    );

    // Arbiter side.
    modport slave (
        input  i_valid, i_sop, i_eop, i_data,
        output o_ready, o_valid, o_sop, o_eop, o_data
    );
endinterface

// File: rtl/frame_arbiter.sv
// Round-robin arbiter that merges framed requester streams into one output stream.
// Ownership changes only between frames. A frame runs from its SOP beat to its EOP
// beat. Stray non-SOP beats seen while idle are accepted and dropped. A repeated SOP
// inside a frame is forwarded with o_sop cleared, and o_proto_err pulses.
module frame_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    frame_arbiter_if.slave           bus,
    output logic [$clog2(N_REQ)-1:0] o_grant,
    output logic                     o_busy,
    output logic                     o_proto_err,
    output logic [CNT_W-1:0]         o_drop_cnt,
    output logic [CNT_W-1:0]         o_frame_cnt,
    output logic                     o_dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               started_q;
    logic [N_REQ-1:0]   strays;
    logic [N_REQ-1:0]   ready_c;
    logic               xfer;
    logic               xfer_eop;
    logic               valid_c;
    logic               sop_c;
    logic               eop_c;
    logic [DATA_W-1:0]  data_c;
    logic               perr_c;
    logic [CNT_W-1:0]   drop_q;
    logic [CNT_W-1:0]   frame_q;
    int                 cand;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, round-robin search and combinational datapath from the owner
    always_comb begin
        state_d   = state_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        strays    = bus.i_valid & ~bus.i_sop;
        ready_c   = '0;
        xfer      = 1'b0;
        xfer_eop  = 1'b0;
        valid_c   = 1'b0;
        sop_c     = 1'b0;
        eop_c     = 1'b0;
        data_c    = '0;
        perr_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Strays are accepted and dropped. SOP candidates wait for their grant.
                ready_c = strays;
                for (int i = 1; i <= N_REQ; i++) begin
                    cand = (int'(ptr_q) + i) % N_REQ;
                    if (!win_found && bus.i_valid[cand] && bus.i_sop[cand]) begin
                        win_found = 1'b1;
                        win_idx   = IDX_W'(cand);
                    end
                end
                if (win_found) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                ready_c[grant_q] = 1'b1;
                xfer     = bus.i_valid[grant_q];
                valid_c  = xfer;
                data_c   = bus.i_data[grant_q*DATA_W +: DATA_W];
                sop_c    = xfer & ~started_q;
                eop_c    = xfer & bus.i_eop[grant_q];
                perr_c   = xfer & started_q & bus.i_sop[grant_q];
                xfer_eop = eop_c;
                if (xfer_eop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, fairness pointer, in-frame flag and saturating counters
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            grant_q   <= '0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            started_q <= 1'b0;
            drop_q    <= '0;
            frame_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && win_found) begin
                grant_q   <= win_idx;
                started_q <= 1'b0;
            end
            if (xfer) begin
                started_q <= 1'b1;
            end
            if (xfer_eop) begin
                ptr_q <= grant_q;
                if (frame_q != {CNT_W{1'b1}}) begin
                    frame_q <= frame_q + CNT_W'(1);
                end
            end
            if (state_q == ST_IDLE && (|strays) && drop_q != {CNT_W{1'b1}}) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    // Combinational outputs are forced low while reset is held
    assign bus.o_ready  = ready_c & {N_REQ{i_arst_n}};
    assign bus.o_valid  = valid_c & i_arst_n;
    assign bus.o_sop    = sop_c & i_arst_n;
    assign bus.o_eop    = eop_c & i_arst_n;
    assign bus.o_data   = data_c & {DATA_W{i_arst_n}};
    assign o_proto_err  = perr_c & i_arst_n;
    assign o_grant      = grant_q;
    assign o_busy       = (state_q == ST_BUSY);
    assign o_drop_cnt   = drop_q;
    assign o_frame_cnt  = frame_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_frame_arbiter.sv
// Bench for frame_arbiter. Expected output beats go into a queue when stimulus is
// issued. A monitor on the falling edge pops an entry and compares it with every
// output beat.
module tb_frame_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    frame_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    logic [1:0]    grant;
    logic          busy;
    logic          perr;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] frame_cnt;
    logic          dbg_state;

    frame_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .bus         (bus.slave),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_proto_err (perr),
        .o_drop_cnt  (drop_cnt),
        .o_frame_cnt (frame_cnt),
        .o_dbg_state (dbg_state)
    );

    // scoreboard state
    int          n_checks = 0;
    int          n_pass = 0;
    int          perr_seen = 0;
    logic [11:0] exp_q[$];
    int          beat_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] pk(input int g, input bit s, input bit e, input logic [7:0] d);
        return {2'(g), s, e, d};
    endfunction

    // monitor: every output beat must match the head of the expected queue
    always @(negedge clk) begin
        logic [11:0] act;
        logic [11:0] exp;
        if (rst_n && bus.o_valid) begin
            act = {grant, bus.o_sop, bus.o_eop, bus.o_data};
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL beat: got %h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                check("beat", 32'(act), 32'(exp));
            end
        end
        if (perr) perr_seen++;
    end

    // driver: one frame of n beats from requester k; nested_at marks an extra SOP beat
    task automatic send_frame(input int k, input int n, input logic [7:0] base, input int nested_at);
        int waited;
        for (int b = 0; b < n; b++) begin
            bus.i_valid[k] = 1'b1;
            bus.i_sop[k]   = (b == 0) || (b == nested_at);
            bus.i_eop[k]   = (b == n - 1);
            bus.i_data[k*DW +: DW] = base + 8'(b);
            waited = 0;
            @(negedge clk);
            while (!bus.o_ready[k] && waited < 64) begin
                @(negedge clk);
                waited++;
            end
            if (!bus.o_ready[k]) begin
                n_checks++;
                $display("FAIL timeout: req %0d beat %0d got ready=0 expected 1", k, b);
                bus.i_valid[k] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.i_valid[k] = 1'b0;
        bus.i_sop[k]   = 1'b0;
        bus.i_eop[k]   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bus.i_valid = '1;
        bus.i_sop   = '0;
        bus.i_eop   = '0;
        bus.i_data  = '0;

        // reset: strays present, yet every output stays low
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.o_ready), 0);
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_frame", 32'(frame_cnt), 0);
        check("rst_state", 32'(dbg_state), 0);
        bus.i_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single requester 3-beat frame
        exp_q.push_back(pk(0, 1, 0, 8'hA1));
        exp_q.push_back(pk(0, 0, 0, 8'hA2));
        exp_q.push_back(pk(0, 0, 1, 8'hA3));
        send_frame(0, 3, 8'hA1, -1);
        repeat (2) @(negedge clk);
        check("t1_frame_cnt", 32'(frame_cnt), 1);
        check("t1_grant", 32'(grant), 0);
        check("t1_busy", 32'(busy), 0);

        // reset pulse clears the counters asynchronously
        rst_n = 1'b0;
        #1;
        check("rstp_frame", 32'(frame_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // fairness: three requesters each offer two 1-beat frames
        beat_cyc.delete();
        exp_q.push_back(pk(0, 1, 1, 8'h10));
        exp_q.push_back(pk(1, 1, 1, 8'h20));
        exp_q.push_back(pk(2, 1, 1, 8'h30));
        exp_q.push_back(pk(0, 1, 1, 8'h11));
        exp_q.push_back(pk(1, 1, 1, 8'h21));
        exp_q.push_back(pk(2, 1, 1, 8'h31));
        fork
            begin send_frame(0, 1, 8'h10, -1); send_frame(0, 1, 8'h11, -1); end
            begin send_frame(1, 1, 8'h20, -1); send_frame(1, 1, 8'h21, -1); end
            begin send_frame(2, 1, 8'h30, -1); send_frame(2, 1, 8'h31, -1); end
        join
        check("fair_beats", beat_cyc.size(), 6);
        if (beat_cyc.size() == 6) begin
            for (int i = 1; i < 6; i++) check("fair_gap", beat_cyc[i] - beat_cyc[i-1], 2);
        end

        // no interleave: req1 raises SOP while req0 is mid-frame
        exp_q.push_back(pk(0, 1, 0, 8'h40));
        exp_q.push_back(pk(0, 0, 0, 8'h41));
        exp_q.push_back(pk(0, 0, 0, 8'h42));
        exp_q.push_back(pk(0, 0, 1, 8'h43));
        exp_q.push_back(pk(1, 1, 0, 8'h50));
        exp_q.push_back(pk(1, 0, 1, 8'h51));
        fork
            send_frame(0, 4, 8'h40, -1);
            begin repeat (2) @(posedge clk); #1; send_frame(1, 2, 8'h50, -1); end
            begin
                repeat (3) @(negedge clk);
                check("ilv_ready1_a", 32'(bus.o_ready[1]), 0);
                check("ilv_ready0", 32'(bus.o_ready[0]), 1);
                @(negedge clk);
                check("ilv_ready1_b", 32'(bus.o_ready[1]), 0);
            end
        join

        // stray beats in IDLE
        bus.i_valid[3] = 1'b1;
        bus.i_data[3*DW +: DW] = 8'h55;
        @(negedge clk);
        check("stray_ready3", 32'(bus.o_ready[3]), 1);
        check("stray_valid", 32'(bus.o_valid), 0);
        @(posedge clk); #1;
        bus.i_valid[3] = 1'b0;
        @(negedge clk);
        check("stray_drop1", 32'(drop_cnt), 1);
        @(posedge clk); #1;
        bus.i_valid[3:2] = 2'b11;
        @(negedge clk);
        check("stray_ready2", 32'(bus.o_ready), 32'hC);
        @(posedge clk); #1;
        bus.i_valid[3:2] = 2'b00;
        @(negedge clk);
        check("stray_drop2", 32'(drop_cnt), 2);
        @(posedge clk); #1;
        bus.i_valid[3] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus.i_valid[3] = 1'b0;
        @(negedge clk);
        check("drop_sat", 32'(drop_cnt), 15);

        // nested SOP inside req2 frame
        @(posedge clk); #1;
        p0 = perr_seen;
        exp_q.push_back(pk(2, 1, 0, 8'h60));
        exp_q.push_back(pk(2, 0, 0, 8'h61));
        exp_q.push_back(pk(2, 0, 1, 8'h62));
        send_frame(2, 3, 8'h60, 1);
        @(negedge clk);
        check("nest_perr", perr_seen - p0, 1);
        check("nest_frame_cnt", 32'(frame_cnt), 9);

        // reset during beat 2 of a 4-beat req1 frame
        @(posedge clk); #1;
        exp_q.push_back(pk(1, 1, 0, 8'h70));
        bus.i_valid[1] = 1'b1;
        bus.i_sop[1]   = 1'b1;
        bus.i_eop[1]   = 1'b0;
        bus.i_data[1*DW +: DW] = 8'h70;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.i_sop[1] = 1'b0;
        bus.i_data[1*DW +: DW] = 8'h71;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(bus.o_valid), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_ready", 32'(bus.o_ready), 0);
        check("mrst_state", 32'(dbg_state), 0);
        bus.i_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.push_back(pk(0, 1, 1, 8'h80));
        exp_q.push_back(pk(1, 1, 1, 8'h90));
        fork
            send_frame(0, 1, 8'h80, -1);
            send_frame(1, 1, 8'h90, -1);
        join
        @(negedge clk);
        check("mrst_frame_cnt", 32'(frame_cnt), 2);

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
